// File: rtl/csel_addsub_seq.sv
// csel_addsub_seq: sequential nibble-serial adder/subtractor.
// Each busy cycle adds one 4-bit slice, LSB first, using a carry-select slice.
// The slice computes the carry-0 and carry-1 sums up front.
// The registered running carry then picks one of them.
// Subtract is formed as a + ~b + ~c_in, so the carry out of the top slice is an inverted borrow.
// Optional feature: define CSEL_ADDSUB_OVF_EN to add a signed-overflow output, ovf.
module csel_addsub_seq #(
  parameter int unsigned NIBBLES = 4,
  localparam int unsigned W = 4 * NIBBLES
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         op_sub,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         c_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] result,
  output logic         c_out
`ifdef CSEL_ADDSUB_OVF_EN
  ,
  output logic         ovf
`endif
);

  localparam int unsigned CW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [CW-1:0] cnt;
  logic          carry;
  logic [W-1:0]  a_r;
  logic [W-1:0]  b_r;
  logic          op_r;
  logic          accept;
  logic          last;
  logic [4:0]    sum0;
  logic [4:0]    sum1;
  logic [4:0]    sel;
`ifdef CSEL_ADDSUB_OVF_EN
  logic          c_msb;
`endif

  // Next-state logic: take an op only when idle, and release the result on the consumer handshake.
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    last      = (cnt == CW'(NIBBLES - 1));
    case (state)
      IDLE: begin
        if (in_valid) begin
          accept    = 1'b1;
          state_nxt = BUSY;
        end
      end
      BUSY: begin
        if (last) state_nxt = DONE;
      end
      DONE: begin
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Carry-select slice on the low nibble of the shifting operand registers.
  always_comb begin
    sum0 = {1'b0, a_r[3:0]} + {1'b0, b_r[3:0]};
    sum1 = sum0 + 5'd1;
    sel  = carry ? sum1 : sum0;
  end

`ifdef CSEL_ADDSUB_OVF_EN
  // Carry into the top bit is recovered from that bit's sum and its operand bits.
  assign c_msb = sel[3] ^ a_r[3] ^ b_r[3];
`endif

  // State register plus the handshake flags, which are registered from the next state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      state     <= state_nxt;
      in_ready  <= (state_nxt == IDLE);
      out_valid <= (state_nxt == DONE);
    end
  end

  // Operand capture, one slice per busy cycle, and the final carry/borrow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_r    <= '0;
      b_r    <= '0;
      op_r   <= 1'b0;
      carry  <= 1'b0;
      cnt    <= '0;
      result <= '0;
      c_out  <= 1'b0;
`ifdef CSEL_ADDSUB_OVF_EN
      ovf    <= 1'b0;
`endif
    end else if (accept) begin
      a_r   <= a;
      b_r   <= op_sub ? ~b : b;
      op_r  <= op_sub;
      carry <= op_sub ? ~c_in : c_in;
      cnt   <= '0;
    end else if (state == BUSY) begin
      a_r    <= a_r >> 4;
      b_r    <= b_r >> 4;
      result <= W'({sel[3:0], result} >> 4);
      carry  <= sel[4];
      cnt    <= cnt + CW'(1);
      if (last) begin
        c_out <= op_r ? ~sel[4] : sel[4];
`ifdef CSEL_ADDSUB_OVF_EN
        ovf   <= c_msb ^ sel[4];
`endif
      end
    end
  end

endmodule

// File: tb/tb_csel_addsub_seq.sv
// tb_csel_addsub_seq: directed vectors checked against an arithmetic model.
// A compare process checks the handshake and the result on every cycle.
// Literal expectations pin the model to hand-computed answers.
module tb_csel_addsub_seq;

  localparam int unsigned N = 4;
  localparam int unsigned W = 16;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         op_sub = 1'b0;
  logic         c_in = 1'b0;
  logic         out_ready = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         in_ready;
  logic         out_valid;
  logic         c_out;
  logic [W-1:0] result;
`ifdef CSEL_ADDSUB_OVF_EN
  logic         ovf;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  csel_addsub_seq #(.NIBBLES(N)) dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .op_sub(op_sub),
    .a(a),
    .b(b),
    .c_in(c_in),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .result(result),
    .c_out(c_out)
`ifdef CSEL_ADDSUB_OVF_EN
    ,
    .ovf(ovf)
`endif
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Model state: whether an operation is outstanding, when it was taken, and its expected outcome.
  bit           pending = 1'b0;
  int           cyc = 0;
  int           acc_cyc = 0;
  logic [W-1:0] m_res = '0;
  logic         m_cout = 1'b0;
  logic         m_ovf = 1'b0;

  // Model: plain wide arithmetic on accepted operands, with the result due N edges after acceptance.
  always @(posedge clk or posedge rst) begin
    logic [W:0]          s17;
    logic signed [W-1:0] sa;
    logic signed [W-1:0] sb;
    int                  sv;
    if (rst) begin
      pending = 1'b0;
    end else begin
      if (!pending && in_valid) begin
        pending = 1'b1;
        acc_cyc = cyc;
        sa = a;
        sb = b;
        if (!op_sub) begin
          s17 = 17'(a) + 17'(b) + 17'(c_in);
          sv  = int'(sa) + int'(sb) + int'(c_in);
        end else begin
          s17 = 17'(a) - 17'(b) - 17'(c_in);
          sv  = int'(sa) - int'(sb) - int'(c_in);
        end
        m_res  = s17[W-1:0];
        m_cout = s17[W];
        m_ovf  = (sv > 32767) || (sv < -32768);
      end else if (pending && (cyc - acc_cyc) >= int'(N) + 1 && out_ready) begin
        pending = 1'b0;
      end
      cyc++;
    end
  end

  // Compare process: handshake flags every cycle, and the payload whenever a result is due.
  always @(negedge clk) begin
    bit dv;
    if (!rst) begin
      dv = pending && ((cyc - acc_cyc) >= int'(N) + 1);
      chk("in_ready", 32'(in_ready), 32'(!pending));
      chk("out_valid", 32'(out_valid), 32'(dv));
      if (dv) begin
        chk("result", 32'(result), 32'(m_res));
        chk("c_out", 32'(c_out), 32'(m_cout));
`ifdef CSEL_ADDSUB_OVF_EN
        chk("ovf", 32'(ovf), 32'(m_ovf));
`endif
      end
    end
  end

  // Issue one op, scramble the inputs while it is busy, hold off the consumer, then hand it off.
  task automatic run_op(input string nm, input bit op, input logic [W-1:0] av, input logic [W-1:0] bv,
                        input bit ci, input int hold, input logic [W-1:0] lres, input bit lco,
                        input bit lov);
    int lat;
    @(negedge clk);
    a = av; b = bv; op_sub = op; c_in = ci; in_valid = 1'b1; out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0; a = ~av; b = W'($urandom); c_in = ~ci; op_sub = ~op;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk({nm, " latency"}, 32'(lat), 32'(N));
    chk({nm, " result lit"}, 32'(result), 32'(lres));
    chk({nm, " c_out lit"}, 32'(c_out), 32'(lco));
`ifdef CSEL_ADDSUB_OVF_EN
    chk({nm, " ovf lit"}, 32'(ovf), 32'(lov));
`else
    if (lov && !lco && nm.len() == 0) $display("note: empty name");
`endif
    for (int i = 0; i < hold; i++) begin
      in_valid = i[0]; a = W'($urandom); b = W'($urandom);
      @(negedge clk);
    end
    out_ready = 1'b1; in_valid = 1'b1;
    @(negedge clk);
    out_ready = 1'b0; in_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst in_ready", 32'(in_ready), 32'h1);
    chk("rst out_valid", 32'(out_valid), 32'h0);
    chk("rst result", 32'(result), 32'h0);
    chk("rst c_out", 32'(c_out), 32'h0);
    rst = 1'b0;

    run_op("add1234", 1'b0, 16'h1234, 16'h0001, 1'b0, 0, 16'h1235, 1'b0, 1'b0);
    run_op("addffff", 1'b0, 16'hFFFF, 16'h0000, 1'b1, 0, 16'h0000, 1'b1, 1'b0);
    run_op("sub0-1", 1'b1, 16'h0000, 16'h0001, 1'b0, 0, 16'hFFFF, 1'b1, 1'b0);
    run_op("sub5000", 1'b1, 16'h5000, 16'h1000, 1'b1, 0, 16'h3FFF, 1'b0, 1'b0);
    run_op("add7fff", 1'b0, 16'h7FFF, 16'h0001, 1'b0, 0, 16'h8000, 1'b0, 1'b1);
    run_op("sub8000", 1'b1, 16'h8000, 16'h0001, 1'b0, 0, 16'h7FFF, 1'b0, 1'b1);
    run_op("bp_add", 1'b0, 16'hA5A5, 16'h5A5A, 1'b0, 5, 16'hFFFF, 1'b0, 1'b0);
    run_op("add0fff", 1'b0, 16'h0FFF, 16'h0001, 1'b0, 2, 16'h1000, 1'b0, 1'b0);
    run_op("sub3-3-1", 1'b1, 16'h0003, 16'h0003, 1'b1, 0, 16'hFFFF, 1'b1, 1'b0);
    run_op("addcarry", 1'b0, 16'h8000, 16'h8000, 1'b1, 0, 16'h0001, 1'b1, 1'b1);

    // Reset during the second busy cycle discards the op.
    @(negedge clk);
    a = 16'hABCD; b = 16'h1111; op_sub = 1'b0; c_in = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    chk("midrst out_valid", 32'(out_valid), 32'h0);
    chk("midrst in_ready", 32'(in_ready), 32'h1);
    chk("midrst result", 32'(result), 32'h0);
    chk("midrst c_out", 32'(c_out), 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    run_op("postrst", 1'b0, 16'h1111, 16'h2222, 1'b1, 0, 16'h3334, 1'b0, 1'b0);

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
